max7219_chain_ctrl: RTL and testbench

- Drives a daisy-chain of N_DEV MAX7219 8x8 LED matrix drivers over a write-only, SPI mode 0 link with its own bit shifter.
- Holds a per-device 8-row frame buffer written by user logic.
- Initialises every device after reset and pushes the frame buffer on request.
- Keeps CS low for the complete 16*N_DEV-bit chain frame, so every device latches on the same CS rising edge.

---
 rtl/max7219_chain_ctrl.sv | 100 ++++++++++
 tb/tb_max7219_chain_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_chain_ctrl.sv
// max7219_chain_ctrl: MAX7219 daisy-chain init/row refresh controller with its own SPI mode 0 shifter
// Define MAX7219_AUTOREFRESH_EN to re-run INIT+ROWS after REFRESH_CYCLES idle cycles
module max7219_chain_ctrl #(
   parameter int N_DEV = 4,
   parameter int CLK_DIV = 4,
   parameter int REFRESH_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_dev,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       update,
   input  logic [3:0] intensity,
   output logic       busy,
   output logic       done,
   output logic       mosi,
   output logic       sclk,
   output logic       cs
);
   localparam int W = 16 * N_DEV;
   localparam int HW = $clog2(2 * W + 3);
   localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int DW = N_DEV > 1 ? $clog2(N_DEV) : 1;
   localparam logic [HW-1:0] H_TAIL = HW'(2 * W + 2);
   typedef enum logic [1:0] {S_IDLE, S_INIT, S_ROWS, S_INTF} state_t;
   state_t state, state_n, seq_n;
   logic [HW-1:0] h;
   logic [CW-1:0] dcnt;
   logic [2:0] fidx;
   logic [W-1:0] sr, word;
   logic [7:0] fb [N_DEV][8];
   logic [3:0] int_sent;
   logic [15:0] init_w;
   logic upd_pend, hend, bit_hi, latch, frame_end, last_frame, seq_end, int_diff, idle_hit, refresh;
   // h counts half-periods: 0..1 cs-high gap, 2..2W+1 data bits, 2W+2 trailing low phase
   assign hend = dcnt == CW'(CLK_DIV - 1);
   assign bit_hi = state != S_IDLE && h[0] && h > HW'(2) && h < H_TAIL;
   assign latch = state != S_IDLE && h == HW'(1) && hend;
   assign frame_end = state != S_IDLE && h == H_TAIL && hend;
   assign last_frame = state == S_INTF || (state == S_INIT && fidx == 3'd4) || (state == S_ROWS && fidx == 3'd7);
   assign seq_end = frame_end && last_frame;
   assign int_diff = intensity != int_sent;
   assign init_w = fidx == 3'd0 ? 16'h0C01 : fidx == 3'd1 ? 16'h0900 : fidx == 3'd2 ? {12'h0A0, intensity} :
                   fidx == 3'd3 ? 16'h0B07 : 16'h0F00;
   assign refresh = REFRESH_CYCLES > 0 && idle_hit;
`ifdef MAX7219_AUTOREFRESH_EN
   logic [31:0] idle_cnt;
   always_ff @(posedge clk)
      idle_cnt <= (!reset || state != S_IDLE || update || int_diff) ? '0 : idle_cnt + 32'd1;
   assign idle_hit = idle_cnt == 32'(REFRESH_CYCLES - 1);
`else
   assign idle_hit = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_INIT;
         h <= '0;
         dcnt <= '0;
         fidx <= '0;
         sr <= '0;
         int_sent <= '0;
         upd_pend <= 1'b0;
         done <= 1'b0;
         for (int d = 0; d < N_DEV; d++)
            for (int r = 0; r < 8; r++)
               fb[d][r] <= '0;
      end else begin
         state <= state_n;
         done <= state != S_IDLE && state_n == S_IDLE;
         dcnt <= (state == S_IDLE || hend) ? '0 : dcnt + 1'b1;
         h <= (state == S_IDLE || frame_end) ? '0 : hend ? h + 1'b1 : h;
         fidx <= (state == S_IDLE || seq_end) ? '0 : frame_end ? fidx + 3'd1 : fidx;
         upd_pend <= (state_n == S_ROWS && (state == S_IDLE || seq_end)) ? 1'b0 : upd_pend || update;
         sr <= latch ? word : (bit_hi && hend) ? sr << 1 : sr;
         if (latch && (state == S_INTF || (state == S_INIT && fidx == 3'd2)))
            int_sent <= intensity;
         if (wr_en && 4'(wr_dev) < 4'(N_DEV))
            fb[wr_dev[DW-1:0]][wr_row] <= wr_data;
      end
   end
   // intensity outranks a pending row push; INIT is always followed by ROWS
   always_comb begin
      seq_n = int_diff ? S_INTF : (upd_pend || update) ? S_ROWS : refresh ? S_INIT : S_IDLE;
      state_n = state == S_IDLE ? seq_n : !seq_end ? state : state == S_INIT ? S_ROWS : seq_n;
   end
   always_comb begin
      word = '0;
      for (int d = 0; d < N_DEV; d++)
         word[16*d +: 16] = state == S_ROWS ? {8'(fidx) + 8'd1, fb[d][fidx]} :
                            state == S_INTF ? {12'h0A0, intensity} : init_w;
   end
   always_comb begin
      busy = state != S_IDLE;
      cs = !(busy && h > HW'(1));
      sclk = bit_hi;
      mosi = !cs && sr[W-1];
   end
endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// tb_max7219_chain_ctrl: decodes the SPI link into chain words and scores them against frames predicted from the register rules
module tb_max7219_chain_ctrl;
   localparam int N = 2, T = 2, LOW = 32 * N * T + T;
   logic clk = 0, reset = 0, wr_en = 0, update = 0;
   logic [2:0] wr_dev = 0, wr_row = 0;
   logic [7:0] wr_data = 0;
   logic [3:0] intensity = 4'hA;
   logic busy, done, mosi, sclk, cs;
   int checks = 0, passed = 0, ndone = 0, last_low = 0;
   logic [31:0] expq[$], rx[$];
   logic [7:0] mfb [N][8];

   max7219_chain_ctrl #(.N_DEV(N), .CLK_DIV(T), .REFRESH_CYCLES(1000)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_dev(wr_dev), .wr_row(wr_row), .wr_data(wr_data),
      .update(update), .intensity(intensity), .busy(busy), .done(done), .mosi(mosi), .sclk(sclk), .cs(cs));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic logic [31:0] bcast(input logic [15:0] w);
      return {w, w};
   endfunction

   task automatic push_init(input logic [3:0] v);
      expq.push_back(bcast(16'h0C01));
      expq.push_back(bcast(16'h0900));
      expq.push_back(bcast({12'h0A0, v}));
      expq.push_back(bcast(16'h0B07));
      expq.push_back(bcast(16'h0F00));
   endtask

   task automatic push_rows;
      for (int r = 1; r <= 8; r++)
         expq.push_back({8'(r), mfb[1][r-1], 8'(r), mfb[0][r-1]});
   endtask

   task automatic push_int(input logic [3:0] v);
      expq.push_back(bcast({12'h0A0, v}));
   endtask

   // SPI monitor: samples mosi on sclk rise, scores each word when cs rises
   logic prst = 0, pcs = 1, psclk = 0, pmosi = 0, pbusy = 1;
   int low_cnt = 0, gap_cnt = 100, bits = 0;
   logic [31:0] sh = 0;
   always @(negedge clk) begin
      if (!prst) begin
         chk("reset_cs", cs, 1);
         chk("reset_sclk", sclk, 0);
         chk("reset_mosi", mosi, 0);
         chk("reset_busy", busy, 1);
         chk("reset_done", done, 0);
         low_cnt = 0;
         bits = 0;
         gap_cnt = 100;
      end else begin
         if (sclk && !psclk) begin
            sh = {sh[30:0], mosi};
            bits++;
         end
         if (!cs) low_cnt++;
         if (cs && !pcs) begin
            chk("frame_bits", bits, 32);
            chk("cs_low_len", low_cnt, LOW);
            chk("frame_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) chk("frame_word", sh, expq.pop_front());
            rx.push_back(sh);
            last_low = low_cnt;
            low_cnt = 0;
            bits = 0;
            gap_cnt = 0;
         end
         if (!cs && pcs) chk("cs_gap", 32'(gap_cnt >= 2 * T), 1);
         if (cs) begin
            gap_cnt++;
            chk("idle_sclk", sclk, 0);
            chk("idle_mosi", mosi, 0);
         end else chk("busy_in_frame", busy, 1);
         if (!cs && !pcs && mosi !== pmosi) chk("mosi_on_fall", psclk && !sclk, 1);
         chk("done_pulse", done, pbusy && !busy);
         if (done) ndone++;
      end
      prst = reset;
      pcs = cs;
      psclk = sclk;
      pmosi = mosi;
      pbusy = busy;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      repeat (3) tick;
      while (busy && n < budget) begin
         tick;
         n++;
      end
      chk("idle_timeout", busy, 0);
      repeat (2) tick;
   endtask

   task automatic write(input int d, input int r, input logic [7:0] v);
      wr_en = 1;
      wr_dev = 3'(d);
      wr_row = 3'(r);
      wr_data = v;
      if (d < N) mfb[d][r] = v;
      tick;
      wr_en = 0;
   endtask

   task automatic pulse_update;
      update = 1;
      tick;
      update = 0;
   endtask

   initial begin
      int n0, d0, falls, n;
      logic pc;
      foreach (mfb[d, r]) mfb[d][r] = 8'h00;
      repeat (4) tick;
      chk("hold_busy", busy, 1);
      chk("hold_cs", cs, 1);
      push_init(4'hA);
      push_rows;
      reset = 1;
      wait_idle(4000);
      chk("init_frames", rx.size(), 13);
      chk("init_done", ndone, 1);
      chk("init_first", rx[0], 32'h0C010C01);
      chk("init_intensity", rx[2], 32'h0A0A0A0A);
      chk("init_row1", rx[5], 32'h01000100);
      chk("cs_low_130", last_low, 130);

      n0 = rx.size();
      d0 = ndone;
      write(1, 0, 8'hA5);
      write(0, 0, 8'h3C);
      write(2, 0, 8'hFF);
      wr_en = 1; wr_dev = 0; wr_row = 7; wr_data = 8'h81; update = 1;
      mfb[0][7] = 8'h81;
      tick;
      wr_en = 0; update = 0;
      push_rows;
      wait_idle(2000);
      chk("rows_frames", rx.size() - n0, 8);
      chk("rows_f1", rx[n0], 32'h01A5013C);
      chk("rows_f2", rx[n0+1], 32'h02000200);
      chk("rows_f8_same_cycle_write", rx[n0+7], 32'h08000881);
      chk("rows_done", ndone - d0, 1);

      n0 = rx.size();
      d0 = ndone;
      pulse_update;
      push_rows;
      push_rows;
      repeat (300) tick;
      pulse_update;
      repeat (50) tick;
      pulse_update;
      repeat (50) tick;
      pulse_update;
      wait_idle(4000);
      chk("coalesce_frames", rx.size() - n0, 16);
      chk("coalesce_done", ndone - d0, 1);

      n0 = rx.size();
      d0 = ndone;
      intensity = 4'h3;
      push_int(4'h3);
      wait_idle(1000);
      chk("int_frames", rx.size() - n0, 1);
      chk("int_word", rx[n0], 32'h0A030A03);
      chk("int_done", ndone - d0, 1);

      n0 = rx.size();
      d0 = ndone;
      intensity = 4'h5;
      update = 1;
      tick;
      update = 0;
      push_int(4'h5);
      push_rows;
      wait_idle(3000);
      chk("prio_frames", rx.size() - n0, 9);
      chk("prio_int_first", rx[n0], 32'h0A050A05);
      chk("prio_rows_next", rx[n0+1], 32'h01A5013C);
      chk("prio_done", ndone - d0, 1);

      pulse_update;
      push_rows;
      falls = 0;
      n = 0;
      pc = cs;
      while (falls < 4 && n < 3000) begin
         tick;
         n++;
         if (pc && !cs) falls++;
         pc = cs;
      end
      chk("frame4_reached", falls, 4);
      repeat (41) tick;
      reset = 0;
      expq.delete();
      tick;
      chk("abort_cs", cs, 1);
      chk("abort_sclk", sclk, 0);
      chk("abort_mosi", mosi, 0);
      foreach (mfb[d, r]) mfb[d][r] = 8'h00;
      repeat (3) tick;
      push_init(4'h5);
      push_rows;
      n0 = rx.size();
      d0 = ndone;
      reset = 1;
      wait_idle(4000);
      chk("reinit_frames", rx.size() - n0, 13);
      chk("reinit_first", rx[n0], 32'h0C010C01);
      chk("reinit_fb_clear", rx[n0+5], 32'h01000100);
      chk("reinit_done", ndone - d0, 1);

      n0 = rx.size();
      repeat (5000) tick;
      chk("no_auto_frames", rx.size() - n0, 0);
      chk("quiet_busy", busy, 0);
      chk("exp_drained", expq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
